hack_cpu: RTL and testbench

//  16-bit Hack-ISA accumulator CPU: A, D and PC registers plus a 6-control-bit ALU.

---
 rtl/hack_cpu.sv | 122 ++++++++++++
 tb/tb_hack_cpu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu.sv
// hack_cpu: 16-bit Hack-ISA accumulator core.
// Holds the A, D and PC registers and a 6-control-bit ALU. It talks to a
// synchronous-read instruction ROM and a synchronous-read, write-first data RAM.
// Because both memories register their read data, the core presents the *next*
// fetch address and the *next* data address combinationally, so the word for the
// following instruction is already on memory_i / instruction when it executes.
// The reset input is active-low and asynchronous; while it is low every
// externally visible control output is forced to zero.
module hack_cpu (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instruction,
   output logic [14:0] next_instruction_addr_o,
   output logic [14:0] memory_addr_o,
   output logic        memory_we_o,
   input  logic [15:0] memory_i,
   output logic [15:0] memory_o
);

   // Architectural state and next-state values.
   logic [15:0] a_q, a_d;
   logic [15:0] d_q, d_d;
   logic [14:0] pc_q, pc_d;

   // Instruction fields. For an A-instruction only is_c matters (it is 0).
   logic       is_c;
   logic       sel_m;
   logic       zx, nx, zy, ny, fn, no;
   logic       dst_a, dst_d, dst_m;
   logic       j_lt, j_eq, j_gt;

   // ALU operands, intermediate values and flags.
   logic [15:0] alu_y;
   logic [15:0] x_z, x_n, y_z, y_n;
   logic [15:0] alu_f;
   logic [15:0] alu_out;
   logic        alu_zr, alu_ng;
   logic        jump_taken;
   logic        write_m;

   // Bits 14:13 of a C-instruction carry no meaning in this ISA.
   logic unused_bits;
   assign unused_bits = ^instruction[14:13];

   // Split the instruction word into its control fields.
   always_comb begin
      is_c  = instruction[15];
      sel_m = instruction[12];
      zx    = instruction[11];
      nx    = instruction[10];
      zy    = instruction[9];
      ny    = instruction[8];
      fn    = instruction[7];
      no    = instruction[6];
      dst_a = instruction[5];
      dst_d = instruction[4];
      dst_m = instruction[3];
      j_lt  = instruction[2];
      j_eq  = instruction[1];
      j_gt  = instruction[0];
   end

   // Hack ALU: x is always D, y is A or M depending on the a-bit.
   always_comb begin
      alu_y   = sel_m ? memory_i : a_q;
      x_z     = zx ? 16'h0000 : d_q;
      x_n     = nx ? ~x_z : x_z;
      y_z     = zy ? 16'h0000 : alu_y;
      y_n     = ny ? ~y_z : y_z;
      alu_f   = fn ? (x_n + y_n) : (x_n & y_n);
      alu_out = no ? ~alu_f : alu_f;
      alu_zr  = (alu_out == 16'h0000);
      alu_ng  = alu_out[15];
   end

   // Jump decision and register next-state; A-instructions never jump.
   always_comb begin
      a_d        = a_q;
      d_d        = d_q;
      pc_d       = pc_q + 15'd1;
      write_m    = 1'b0;
      jump_taken = 1'b0;
      if (!is_c) begin
         a_d = {1'b0, instruction[14:0]};
      end else begin
         jump_taken = (j_lt & alu_ng) | (j_eq & alu_zr) | (j_gt & ~alu_zr & ~alu_ng);
         write_m    = dst_m;
         if (dst_a) a_d = alu_out;
         if (dst_d) d_d = alu_out;
         // The jump target is the A value held before this edge.
         if (jump_taken) pc_d = a_q[14:0];
      end
   end

   // Memory-side outputs. A write targets the current A; otherwise present the
   // A value of the next instruction so its M is ready when it executes.
   always_comb begin
      memory_o                = alu_out;
      memory_we_o             = 1'b0;
      memory_addr_o           = 15'h0000;
      next_instruction_addr_o = 15'h0000;
      if (reset) begin
         memory_we_o             = write_m;
         memory_addr_o           = write_m ? a_q[14:0] : a_d[14:0];
         next_instruction_addr_o = pc_d;
      end
   end

   // Register update with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q  <= 16'h0000;
         d_q  <= 16'h0000;
         pc_q <= 15'h0000;
      end else begin
         a_q  <= a_d;
         d_q  <= d_d;
         pc_q <= pc_d;
      end
   end

endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: directed program for hack_cpu with registered ROM/RAM models.
module tb_hack_cpu;

   logic        clk;
   logic        reset;
   logic [15:0] instruction;
   logic [14:0] next_addr;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [15:0] memory_i;
   logic [15:0] memory_o;

   logic [15:0] rom [0:32767];
   logic [15:0] ram [0:16383];

   int n_tests = 0;
   int n_fail  = 0;

   // Hack comp encodings for the sweep, in order:
   // 0,1,-1,D,A,!D,!A,-D,-A,D+1,A+1,D-1,A-1,D+A,D-A,A-D,D&A,D|A
   logic [5:0] sweep_c [0:17] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100,
                                  6'b110000, 6'b001101, 6'b110001, 6'b001111,
                                  6'b110011, 6'b011111, 6'b110111, 6'b001110,
                                  6'b110010, 6'b000010, 6'b010011, 6'b000111,
                                  6'b000000, 6'b010101};
   // Expected results with D=0x0011, A=0x0003.
   logic [15:0] sweep_e [0:17] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0011,
                                   16'h0003, 16'hFFEE, 16'hFFFC, 16'hFFEF,
                                   16'hFFFD, 16'h0012, 16'h0004, 16'h0010,
                                   16'h0002, 16'h0014, 16'h000E, 16'hFFF2,
                                   16'h0001, 16'h0013};

   hack_cpu dut (
      .clk                     (clk),
      .reset                   (reset),
      .instruction             (instruction),
      .next_instruction_addr_o (next_addr),
      .memory_addr_o           (mem_addr),
      .memory_we_o             (mem_we),
      .memory_i                (memory_i),
      .memory_o                (memory_o)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered ROM read and write-first RAM.
   always @(posedge clk) begin
      instruction <= rom[next_addr];
      if (mem_we) begin
         ram[mem_addr[13:0]] <= memory_o;
         memory_i            <= memory_o;
      end else begin
         memory_i <= ram[mem_addr[13:0]];
      end
   end

   function automatic logic [15:0] ci(input logic a, input logic [5:0] c,
                                      input logic [2:0] d, input logic [2:0] j);
      return {3'b111, a, c, d, j};
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   // Advance to the next instruction; sample on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
      for (int i = 0; i < 16384; i++) ram[i] = 16'h0000;

      rom[0]  = 16'd21;                               // @21
      rom[1]  = ci(1'b0, 6'b110000, 3'b010, 3'b000);  // D=A
      rom[2]  = 16'd5;                                // @5
      rom[3]  = ci(1'b0, 6'b000010, 3'b010, 3'b000);  // D=D+A
      rom[4]  = 16'd0;                                // @0
      rom[5]  = ci(1'b0, 6'b001100, 3'b001, 3'b000);  // M=D
      rom[6]  = 16'd17;                               // @17
      rom[7]  = ci(1'b0, 6'b110000, 3'b010, 3'b000);  // D=A
      rom[8]  = 16'd3;                                // @3
      for (int i = 0; i < 18; i++) rom[9+i] = ci(1'b0, sweep_c[i], 3'b000, 3'b000);
      rom[27] = 16'h0007;                             // @7 (low bits look like JMP)
      rom[28] = ci(1'b0, 6'b111111, 3'b001, 3'b000);  // M=1
      rom[29] = ci(1'b1, 6'b110000, 3'b010, 3'b000);  // D=M
      rom[30] = 16'd7;                                // @7
      rom[31] = ci(1'b1, 6'b110111, 3'b010, 3'b000);  // D=M+1
      rom[32] = ci(1'b0, 6'b001100, 3'b101, 3'b000);  // AM=D
      rom[33] = ci(1'b0, 6'b111010, 3'b010, 3'b000);  // D=-1
      rom[34] = 16'd40;                               // @40
      rom[35] = ci(1'b0, 6'b001100, 3'b000, 3'b100);  // D;JLT
      rom[40] = ci(1'b0, 6'b101010, 3'b010, 3'b000);  // D=0
      rom[41] = 16'd50;                               // @50
      rom[42] = ci(1'b0, 6'b001100, 3'b000, 3'b101);  // D;JNE
      rom[43] = ci(1'b0, 6'b001100, 3'b000, 3'b010);  // D;JEQ
      rom[50] = 16'd60;                               // @60
      rom[51] = ci(1'b0, 6'b101010, 3'b000, 3'b111);  // 0;JMP
      rom[60] = 16'h7FFF;                             // @32767
      rom[61] = ci(1'b0, 6'b110000, 3'b010, 3'b000);  // D=A
      rom[62] = ci(1'b0, 6'b011111, 3'b010, 3'b000);  // D=D+1
      rom[63] = 16'd70;                               // @70
      rom[64] = ci(1'b0, 6'b001100, 3'b000, 3'b001);  // D;JGT
      rom[65] = 16'h7FFF;                             // @32767
      rom[66] = ci(1'b0, 6'b101010, 3'b000, 3'b111);  // 0;JMP
      rom[32767] = ci(1'b0, 6'b001100, 3'b000, 3'b000); // D (nop)

      // Reset held low.
      #1;
      check("rst_next", {1'b0, next_addr}, 16'h0000);
      check("rst_we",   {15'h0, mem_we},   16'h0000);
      check("rst_addr", {1'b0, mem_addr},  16'h0000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;

      // c0 @21
      check("c0_next", {1'b0, next_addr}, 16'd1);
      check("c0_we",   {15'h0, mem_we},   16'h0000);
      step(); check("c1_out", memory_o, 16'h0015);
      step(); step(); check("c3_out", memory_o, 16'h001A);
      step(); check("c4_addr", {1'b0, mem_addr}, 16'h0000);
      step();
      check("c5_we",   {15'h0, mem_we},   16'h0001);
      check("c5_addr", {1'b0, mem_addr},  16'h0000);
      check("c5_data", memory_o,          16'h001A);
      check("c5_next", {1'b0, next_addr}, 16'd6);
      step(); check("c6_we", {15'h0, mem_we}, 16'h0000);
      check("ram0", ram[0], 16'h001A);
      step(); step(); step();

      // ALU sweep, c9..c26
      for (int i = 0; i < 18; i++) begin
         check($sformatf("alu_%0d", i), memory_o, sweep_e[i]);
         check($sformatf("alu_pc_%0d", i), {1'b0, next_addr}, 16'(10 + i));
         step();
      end

      // c27 @7: A-instr with low bits 111 must not jump.
      check("c27_next", {1'b0, next_addr}, 16'd28);
      check("c27_addr", {1'b0, mem_addr},  16'd7);
      step();
      check("c28_we",   {15'h0, mem_we},  16'h0001);
      check("c28_addr", {1'b0, mem_addr}, 16'd7);
      check("c28_data", memory_o,         16'h0001);
      step(); check("c29_dm",  memory_o, 16'h0001);
      step(); step(); check("c31_dm1", memory_o, 16'h0002);
      step();
      check("c32_we",   {15'h0, mem_we},  16'h0001);
      check("c32_addr", {1'b0, mem_addr}, 16'd7);
      check("c32_data", memory_o,         16'h0002);
      step(); check("c33_out", memory_o, 16'hFFFF);
      step(); step();
      check("jlt_taken", {1'b0, next_addr}, 16'd40);
      step(); check("c40_out", memory_o, 16'h0000);
      step(); step();
      check("jne_fall", {1'b0, next_addr}, 16'd43);
      step();
      check("jeq_taken", {1'b0, next_addr}, 16'd50);
      step(); step();
      check("jmp_taken", {1'b0, next_addr}, 16'd60);
      step(); step(); step();
      check("c62_out", memory_o, 16'h8000);
      step(); step();
      check("jgt_neg", {1'b0, next_addr}, 16'd65);
      step(); step();
      check("jmp_top", {1'b0, next_addr}, 16'h7FFF);
      step();
      check("wrap_next", {1'b0, next_addr}, 16'h0000);
      check("wrap_d",    memory_o,          16'h8000);
      step();
      check("wrap_c0", {1'b0, next_addr}, 16'd1);

      // Run to M=D, then reset mid-instruction.
      repeat (5) step();
      check("loop_we", {15'h0, mem_we}, 16'h0001);
      #2 reset = 1'b0;
      #1;
      check("mid_next", {1'b0, next_addr}, 16'h0000);
      check("mid_we",   {15'h0, mem_we},   16'h0000);
      check("mid_addr", {1'b0, mem_addr},  16'h0000);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_next", {1'b0, next_addr}, 16'd1);
      check("rel_we",   {15'h0, mem_we},   16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
